// File: rtl/name_col_sequencer.sv
// Column sequencer: streams the "DASUKODA" glyph table one column at a time,
// holding each column for COL_TICKS clocks, with optional looping.
module name_col_sequencer #(
   parameter int unsigned COL_TICKS = 5,
   parameter int unsigned NUM_COLS  = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       hold,
   input  logic       loop_en,
   output logic [5:0] a,
   output logic [5:0] col_idx,
   output logic       col_valid,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned COL_W = 6;
   localparam int unsigned PAT_W = 6;

   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(COL_TICKS - 1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [COL_W-1:0]   r_col;
   logic [PAT_W-1:0]   r_a;
   logic               r_col_valid;
   logic               r_busy;
   logic               r_done;

   logic               w_last_tick;
   logic               w_last_col;
   logic [COL_W-1:0]   w_next_col;
   logic [PAT_W-1:0]   w_next_pat;
   logic [PAT_W-1:0]   w_first_pat;

   // Glyph ROM: four pattern columns per letter followed by a blank spacer.
   function automatic logic [PAT_W-1:0] glyph_col(input logic [COL_W-1:0] idx);
      case (idx)
         // D
         6'd0:  glyph_col = 6'h3F;
         6'd1:  glyph_col = 6'h21;
         6'd2:  glyph_col = 6'h21;
         6'd3:  glyph_col = 6'h1E;
         6'd4:  glyph_col = 6'h00;
         // A
         6'd5:  glyph_col = 6'h3F;
         6'd6:  glyph_col = 6'h09;
         6'd7:  glyph_col = 6'h09;
         6'd8:  glyph_col = 6'h3F;
         6'd9:  glyph_col = 6'h00;
         // S
         6'd10: glyph_col = 6'h37;
         6'd11: glyph_col = 6'h25;
         6'd12: glyph_col = 6'h25;
         6'd13: glyph_col = 6'h3D;
         6'd14: glyph_col = 6'h00;
         // U
         6'd15: glyph_col = 6'h3F;
         6'd16: glyph_col = 6'h20;
         6'd17: glyph_col = 6'h20;
         6'd18: glyph_col = 6'h3F;
         6'd19: glyph_col = 6'h00;
         // K
         6'd20: glyph_col = 6'h3F;
         6'd21: glyph_col = 6'h04;
         6'd22: glyph_col = 6'h0A;
         6'd23: glyph_col = 6'h31;
         6'd24: glyph_col = 6'h00;
         // O
         6'd25: glyph_col = 6'h3F;
         6'd26: glyph_col = 6'h21;
         6'd27: glyph_col = 6'h21;
         6'd28: glyph_col = 6'h3F;
         6'd29: glyph_col = 6'h00;
         // D
         6'd30: glyph_col = 6'h3F;
         6'd31: glyph_col = 6'h21;
         6'd32: glyph_col = 6'h21;
         6'd33: glyph_col = 6'h1E;
         6'd34: glyph_col = 6'h00;
         // A
         6'd35: glyph_col = 6'h3F;
         6'd36: glyph_col = 6'h09;
         6'd37: glyph_col = 6'h09;
         6'd38: glyph_col = 6'h3F;
         6'd39: glyph_col = 6'h00;
         default: glyph_col = 6'h00;
      endcase
   endfunction

   // Advance qualifiers and the pattern to load on the next column step.
   always_comb begin
      w_last_tick = (r_cnt == LAST_TICK);
      w_last_col  = (r_col == LAST_COL);
      w_next_col  = r_col + COL_W'(1);
      w_next_pat  = glyph_col(w_next_col);
      w_first_pat = glyph_col(COL_W'(0));
   end

   // Sequencer FSM with registered outputs; stop always wins, hold freezes RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_col       <= '0;
         r_a         <= '0;
         r_col_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start && !stop) begin
                  r_state     <= RUN;
                  r_cnt       <= '0;
                  r_col       <= '0;
                  r_a         <= w_first_pat;
                  r_col_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end

            RUN: begin
               if (stop) begin
                  r_state     <= IDLE;
                  r_cnt       <= '0;
                  r_col       <= '0;
                  r_a         <= '0;
                  r_col_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b0;
               end else if (!hold) begin
                  if (w_last_tick) begin
                     r_cnt <= '0;
                     if (!w_last_col) begin
                        r_col <= w_next_col;
                        r_a   <= w_next_pat;
                     end else if (loop_en) begin
                        r_col <= '0;
                        r_a   <= w_first_pat;
                     end else begin
                        r_state     <= DONE;
                        r_col       <= '0;
                        r_a         <= '0;
                        r_col_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end

            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end

            default: begin
               r_state     <= IDLE;
               r_cnt       <= '0;
               r_col       <= '0;
               r_a         <= '0;
               r_col_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign a         = r_a;
   assign col_idx   = r_col;
   assign col_valid = r_col_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_name_col_sequencer.sv
// Directed bench for name_col_sequencer: full pass, wrap, stop, hold,
// async reset, start/stop priority and the single-tick corner case.
module tb_name_col_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       start1;
   logic       stop;
   logic       hold;
   logic       loop_en;
   logic [5:0] a,  col_idx;
   logic       col_valid, busy, done;
   logic [5:0] a1, col_idx1;
   logic       col_valid1, busy1, done1;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] REF [40] = '{
      6'h3F, 6'h21, 6'h21, 6'h1E, 6'h00,
      6'h3F, 6'h09, 6'h09, 6'h3F, 6'h00,
      6'h37, 6'h25, 6'h25, 6'h3D, 6'h00,
      6'h3F, 6'h20, 6'h20, 6'h3F, 6'h00,
      6'h3F, 6'h04, 6'h0A, 6'h31, 6'h00,
      6'h3F, 6'h21, 6'h21, 6'h3F, 6'h00,
      6'h3F, 6'h21, 6'h21, 6'h1E, 6'h00,
      6'h3F, 6'h09, 6'h09, 6'h3F, 6'h00
   };

   name_col_sequencer #(.COL_TICKS(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
      .loop_en(loop_en), .a(a), .col_idx(col_idx), .col_valid(col_valid),
      .busy(busy), .done(done)
   );

   name_col_sequencer #(.COL_TICKS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .hold(hold),
      .loop_en(loop_en), .a(a1), .col_idx(col_idx1), .col_valid(col_valid1),
      .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_a"},     32'(a),         32'h0);
      chk({tag, "_col"},   32'(col_idx),   32'h0);
      chk({tag, "_valid"}, 32'(col_valid), 32'h0);
      chk({tag, "_busy"},  32'(busy),      32'h0);
      chk({tag, "_done"},  32'(done),      32'h0);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; start1 = 1'b0;
      stop = 1'b0; hold = 1'b0; loop_en = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      chk_idle("idle_after_reset");

      // Full non-looping pass: cycles 1..200 stream the table, done at 201.
      do_start();
      for (int c = 1; c <= 200; c++) begin
         chk("pass_a",     32'(a),         32'(REF[(c-1)/5]));
         chk("pass_col",   32'(col_idx),   32'((c-1)/5));
         chk("pass_valid", 32'(col_valid), 32'h1);
         chk("pass_done",  32'(done),      32'h0);
         tick(1);
      end
      chk("pass_end_done",  32'(done),      32'h1);
      chk("pass_end_valid", 32'(col_valid), 32'h0);
      chk("pass_end_busy",  32'(busy),      32'h0);
      chk("pass_end_a",     32'(a),         32'h0);
      tick(1);
      chk_idle("pass_idle");

      // Looping pass wraps col 39 straight back to col 0.
      loop_en = 1'b1;
      do_start();
      for (int c = 1; c < 200; c++) begin
         chk("wrap_nodone", 32'(done), 32'h0);
         tick(1);
      end
      chk("wrap_c39_col", 32'(col_idx), 32'd39);
      chk("wrap_c39_a",   32'(a),       32'h00);
      tick(1);
      chk("wrap_col",  32'(col_idx), 32'd0);
      chk("wrap_a",    32'(a),       32'h3F);
      chk("wrap_busy", 32'(busy),    32'h1);
      chk("wrap_done", 32'(done),    32'h0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("run_start_ignored_col", 32'(col_idx), 32'd0);
      chk("run_start_ignored_a",   32'(a),       32'h3F);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk_idle("wrap_stop");
      loop_en = 1'b0;

      // Stop on the column-advance cycle of col 12 (cycle 65).
      do_start();
      tick(64);
      chk("stopadv_col", 32'(col_idx), 32'd12);
      chk("stopadv_a",   32'(a),       32'h25);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk_idle("stopadv");
      tick(1);
      chk_idle("stopadv_after");

      // Hold at col 3 with counter at 2 (cycle 18) for 7 cycles.
      do_start();
      tick(17);
      chk("hold_pre_col", 32'(col_idx), 32'd3);
      hold = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         chk("hold_col", 32'(col_idx), 32'd3);
         chk("hold_a",   32'(a),       32'h1E);
      end
      hold = 1'b0;
      tick(2);
      chk("hold_tail_col", 32'(col_idx), 32'd3);
      chk("hold_tail_a",   32'(a),       32'h1E);
      tick(1);
      chk("hold_next_col", 32'(col_idx), 32'd4);
      chk("hold_next_a",   32'(a),       32'h00);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk_idle("hold_stop");

      // Async reset mid-pass at col 20, outputs clear before the next edge.
      do_start();
      tick(101);
      chk("arst_pre_col", 32'(col_idx), 32'd20);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("arst_async");
      tick(2);
      chk_idle("arst_held");
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("arst_restart_col",   32'(col_idx),   32'd0);
      chk("arst_restart_a",     32'(a),         32'h3F);
      chk("arst_restart_valid", 32'(col_valid), 32'h1);
      chk("arst_restart_done",  32'(done),      32'h0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk_idle("arst_stop");

      // start and stop together in IDLE stay in IDLE.
      start = 1'b1; stop = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b0;
      chk_idle("prio");
      tick(1);
      chk_idle("prio_after");

      // COL_TICKS=1 instance: new column every cycle, done 41 cycles after start.
      start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         chk("t1_a",    32'(a1),       32'(REF[c-1]));
         chk("t1_col",  32'(col_idx1), 32'(c-1));
         chk("t1_done", 32'(done1),    32'h0);
         tick(1);
      end
      chk("t1_done_pulse", 32'(done1),      32'h1);
      chk("t1_done_valid", 32'(col_valid1), 32'h0);
      tick(1);
      chk("t1_done_clear", 32'(done1),      32'h0);
      chk("t1_idle_busy",  32'(busy1),      32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
